fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage ARM pipeline. Holds the program counter and drives the word address into the combinational instruction memory. Registers the returned instruction word and PC+4 into the IF/ID pipeline register for the decode stage. Handles hazard freeze, taken-branch redirect and flush, and keeps two saturating event counters for debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 16: width of the stall and flush counters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `freeze` in 1: hazard-unit stall. Hold the PC and the IF/ID register.
- `branch_taken` in 1: branch resolved taken in EXE. Redirect the PC and flush IF/ID.
- `branch_addr` in 32: branch target byte address.
- `imem_addr` out 32: current PC, to the instruction memory.
- `imem_data` in 32: instruction word. Combinational from `imem_addr`, valid in the same cycle.
- `id_pc` out 32: registered PC+4 of the instruction in IF/ID.
- `id_instruction` out 32: registered instruction word.
- `id_valid` out 1: IF/ID holds a real instruction. Low means bubble.
- `stall_count` out CNT_W: cycles in which `freeze` took effect.
- `flush_count` out CNT_W: cycles in which `branch_taken` took effect.

## Operation
- Internal `pc` register. `imem_addr = pc` combinationally, with no extra cycle.
- `pc_next = pc + 4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- Branch targets are word-aligned: `branch_addr[1:0]` is ignored and forced to 2'b00 on load.
- Per-edge priority, highest first:
  1. `rst`: pc=RESET_PC; id_pc=0; id_instruction=0; id_valid=0; both counters=0.
  2. `branch_taken`, which wins even if `freeze` is high: pc=branch_addr & ~3; id_instruction=0; id_pc=0; id_valid=0; flush_count+1.
  3. `freeze`: pc holds; IF/ID holds all three fields unchanged; stall_count+1.
  4. Otherwise: pc=pc_next; id_instruction=imem_data; id_pc=pc_next; id_valid=1.
- Counters saturate at all-ones and never wrap.
- A zero word in IF/ID is a bubble: id_valid=0 and the instruction is all zeros. Decode must not rely on the encoding alone.

## Timing
- Every output is registered except `imem_addr`, which is `pc`.
- Reset values: `imem_addr`=RESET_PC, `id_pc`=0, `id_instruction`=0, `id_valid`=0, `stall_count`=0, `flush_count`=0.
- Latency: a word at address A appears on `id_instruction` one edge after `imem_addr`=A, with `id_pc`=A+4.
- Branch: target T is on `imem_addr` in the cycle after the `branch_taken` edge. T's instruction reaches IF/ID one edge later. The instruction fetched in the `branch_taken` cycle is discarded.
- Freeze lasting N cycles: `imem_addr` and IF/ID are stable for N cycles. Fetch resumes at the same address with no instruction lost or duplicated.
- `rst` asserted mid-stream overrides `branch_taken` and `freeze` in the same cycle. The first fetch after release is RESET_PC.
- `freeze` and `branch_taken` are sampled only at the clock edge. Glitches between edges have no effect.

## Test plan
- Reset then free-run with memory word(A)=A ^ 32'hA5A5_0000:
  - After the release edge, `imem_addr` steps 0, 4, 8, 12 on successive edges.
  - `id_pc` lags by one edge with values 4, 8, 12.
  - `id_instruction` matches the memory word for the address fetched one edge earlier.
  - `id_valid` goes to 1 on the first active edge.
- Freeze held 3 cycles at `imem_addr`=8:
  - `imem_addr` stays 8 and IF/ID stays at the word from 4 with `id_pc`=8 for 3 cycles.
  - `stall_count`=3.
  - The next edge loads the word from 8 with `id_pc`=12.
- Branch at `imem_addr`=16 with `branch_addr`=32'h0000_0047:
  - Next cycle `imem_addr`=0x44, `id_valid`=0, `id_instruction`=0, `flush_count`=1.
  - The following edge loads the word from 0x44 with `id_pc`=0x48.
- `freeze`=1 and `branch_taken`=1 in the same cycle with `branch_addr`=0x80:
  - The branch wins: `imem_addr`=0x80, bubble in IF/ID.
  - `stall_count` is unchanged and `flush_count` increments.
- Wrap and saturation:
  - Branch to 0xFFFF_FFFC, then one normal edge gives `imem_addr`=0 and `id_pc`=0.
  - With CNT_W=4, 20 freeze cycles leave `stall_count`=15.
- `rst` pulsed while `freeze`=1 at `imem_addr`=0x20: all outputs return to their reset values and the next fetch is RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register,
// branch redirect/flush, hazard freeze and saturating debug counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instruction,
    output logic             id_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{pc: 32'h0, instr: 32'h0, valid: 1'b0};

    logic [31:0]      pc_q, pc_d;
    if_id_t           if_id_q, if_id_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic [31:0] pc_next;
    logic [31:0] br_target;
    logic        unused_br_lsb;

    // Branch wins over freeze, so the selects are made one-hot here.
    logic take_br, take_frz, take_run;

    assign pc_next       = pc_q + 32'd4;
    assign br_target     = {branch_addr[31:2], 2'b00};
    assign unused_br_lsb = ^branch_addr[1:0];

    assign take_br  = branch_taken;
    assign take_frz = freeze & ~branch_taken;
    assign take_run = ~freeze & ~branch_taken;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        stall_d = stall_q;
        flush_d = flush_q;
        unique case (1'b1)
            take_br: begin
                pc_d    = br_target;
                if_id_d = BUBBLE;
                flush_d = sat_inc(flush_q);
            end
            take_frz: begin
                stall_d = sat_inc(stall_q);
            end
            take_run: begin
                pc_d          = pc_next;
                if_id_d.pc    = pc_next;
                if_id_d.instr = imem_data;
                if_id_d.valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            if_id_q <= BUBBLE;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imem_addr      = pc_q;
    assign id_pc          = if_id_q.pc;
    assign id_instruction = if_id_q.instr;
    assign id_valid       = if_id_q.valid;
    assign stall_count    = stall_q;
    assign flush_count    = flush_q;

endmodule
